pred_outcome_tracker: RTL and testbench
=======================================

// Module: pred_outcome_tracker
// PURPOSE
//  Producer side of the tournament meta-predictor update interface. Captures each branch's
//  component predictions (p0 = local, p1 = global) and the meta choice at IF.
//  Holds them in order while the branch is in flight. At WB it compares them with the
//  resolved direction and drives p0_pred_correct / p1_pred_correct / wbisbranch to the
//  choice predictor, plus a mispredict indication to the pipeline.
// PARAMETERS
//  DEPTH  4  in-flight branch entries (IF..WB span); power of two
//  PTR_W  2  log2(DEPTH)
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   asynchronous active-low reset
//  if_push          in   1   IF issues a predicted branch this cycle
//  if_pc            in   16  lc3b_word; PC of that branch
//  if_p0_taken      in   1   local predictor direction
//  if_p1_taken      in   1   global predictor direction
//  if_pred_select   in   1   meta choice (0 = p0, 1 = p1)
//  wb_resolve       in   1   branch retires in WB this cycle
//  wb_pcplus2       in   16  lc3b_word; PC+2 of retiring branch
//  wb_taken         in   1   resolved direction
//  flush            in   1   squash all in-flight branches (redirect)
//  wbisbranch       out  1   valid update to choice predictor (= wb_resolve & !empty)
//  p0_pred_correct  out  1   head.p0_taken == wb_taken
//  p1_pred_correct  out  1   head.p1_taken == wb_taken
//  mispredict       out  1   selected prediction != wb_taken
//  full             out  1   count == DEPTH
//  empty            out  1   count == 0
//  count            out  PTR_W+1  occupancy
//  err_flags        out  3   sticky {pc_mismatch, underflow, overflow}
//  p0_miss_cnt      out  16  saturating count of p0 misses
//  p1_miss_cnt      out  16  saturating count of p1 misses
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers 0, count 0, err_flags 0, miss counters 0, entries invalid.
//    All outputs then read 0, except empty=1.
//  - Entry = {pc[15:0], p0, p1, sel}. Push writes at wr_ptr on the clk edge; pointers wrap mod DEPTH.
//  - WB outputs are combinational from head entry + wb_taken, valid in the same cycle as
//    wb_resolve, so the choice predictor writes with zero added latency. Pop advances rd_ptr on the edge.
//  - Selected prediction = sel ? p1 : p0. mispredict = wbisbranch & (selected != wb_taken).
//  - pc check: (wb_pcplus2 - 16'h2) != head.pc on a valid pop -> set err_flags[2].
//    The pop still occurs.
//  - Underflow: wb_resolve with empty. No pop, wbisbranch=0, correct/mispredict=0, set err_flags[1].
//  - Overflow: push with full and no pop. Push dropped, set err_flags[0].
//    Push+pop when full is legal; count unchanged.
//  - Simultaneous push+pop at any occupancy: both occur, count unchanged.
//    At empty, a push+resolve is an underflow; the push still lands.
//  - flush: the same-cycle pop (WB outputs valid that cycle) is honoured.
//    Then all entries are discarded: count=0, rd_ptr=wr_ptr. Any same-cycle push is dropped.
//  - Miss counters increment on a valid pop when the respective component is wrong.
//    They saturate at 16'hFFFF. They are cleared only by reset.
//  - err_flags are sticky until reset.
// STRUCTURE
//  - lc3b_types gains: typedef struct packed {lc3b_word pc; logic p0, p1, sel;} bp_entry_t.
//  - Storage is one sub-module, bp_entry_fifo: DEPTH x bp_entry_t, async-reset pointers/count,
//    push/pop/flush, combinational head. Comparison, error and counter logic stay in the top.
// TESTING
//  1 Reset mid-run (count=3) -> next cycle count=0, empty=1, err_flags=0, counters=0.
//  2 Push pc=16'h3000 p0=1 p1=0 sel=1; resolve wb_pcplus2=16'h3002 taken=1 ->
//    p0_correct=1, p1_correct=0, mispredict=1, p1_miss_cnt=1.
//  3 Push 4 entries (full), push 5th -> dropped, err_flags=3'b001;
//    4 pops return pcs in order, then resolve -> underflow flag 3'b011.
//  4 full + push+pop same cycle -> count stays 4, FIFO order preserved across pointer wrap.
//  5 count=2, flush+resolve+push same cycle -> head resolved, count=0, push lost;
//    next resolve -> underflow.
//  6 Resolve with wb_pcplus2=16'h3010 vs head pc 16'h3000 ->
//    err_flags[2]=1, entry still popped.

Source files
------------

// File: rtl/pred_outcome_tracker_pkg.sv
// Shared types for the branch-prediction outcome tracker: the in-flight entry
// record, error-flag bit positions and the saturating miss-counter helper.
package pred_outcome_tracker_pkg;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        logic     p0;
        logic     p1;
        logic     sel;
    } bp_entry_t;

    localparam int unsigned BP_DEPTH = 4;
    localparam int unsigned BP_PTR_W = 2;

    localparam int unsigned ERR_PC    = 2;
    localparam int unsigned ERR_UNDER = 1;
    localparam int unsigned ERR_OVER  = 0;

    localparam lc3b_word MISS_MAX = 16'hFFFF;

    function automatic lc3b_word sat_inc(input lc3b_word v, input logic en);
        return (en && (v != MISS_MAX)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/pred_outcome_tracker_fifo.sv
// In-order storage for in-flight branch predictions. Push/pop arrive already
// qualified by the top, but are re-guarded here so the FIFO can never corrupt itself.
module bp_entry_fifo
    import pred_outcome_tracker_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PTR_W = BP_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  bp_entry_t        wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output bp_entry_t        head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    bp_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A flush drops any same-cycle push; a full FIFO only accepts a push when it also pops.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & ~flush_i & (~full_o | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push_en) - (PTR_W+1)'(pop_en);
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_en) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pred_outcome_tracker.sv
// Tracks component/meta predictions from IF to WB and produces same-cycle
// correctness feedback for the choice predictor plus sticky error and miss statistics.
module pred_outcome_tracker
    import pred_outcome_tracker_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PTR_W = BP_PTR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           if_push,
    input  lc3b_word       if_pc,
    input  logic           if_p0_taken,
    input  logic           if_p1_taken,
    input  logic           if_pred_select,
    input  logic           wb_resolve,
    input  lc3b_word       wb_pcplus2,
    input  logic           wb_taken,
    input  logic           flush,
    output logic           wbisbranch,
    output logic           p0_pred_correct,
    output logic           p1_pred_correct,
    output logic           mispredict,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count,
    output logic [2:0]     err_flags,
    output lc3b_word       p0_miss_cnt,
    output lc3b_word       p1_miss_cnt
);

    bp_entry_t head, wdata;
    logic      do_pop, sel_pred, pc_bad, underflow, overflow;
    logic [2:0] err_flags_q, err_flags_d;
    lc3b_word  p0_miss_q, p0_miss_d, p1_miss_q, p1_miss_d;

    assign wdata = '{pc: if_pc, p0: if_p0_taken, p1: if_p1_taken, sel: if_pred_select};

    bp_entry_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (if_push),
        .wdata_i (wdata),
        .pop_i   (do_pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // WB feedback is purely combinational off the head so the choice table updates this cycle.
    assign do_pop          = wb_resolve & ~empty;
    assign wbisbranch      = do_pop;
    assign sel_pred        = head.sel ? head.p1 : head.p0;
    assign p0_pred_correct = do_pop & (head.p0 == wb_taken);
    assign p1_pred_correct = do_pop & (head.p1 == wb_taken);
    assign mispredict      = do_pop & (sel_pred != wb_taken);

    assign pc_bad    = do_pop & ((wb_pcplus2 - 16'h2) != head.pc);
    assign underflow = wb_resolve & empty;
    assign overflow  = if_push & full & ~do_pop & ~flush;

    always_comb begin
        err_flags_d            = err_flags_q;
        err_flags_d[ERR_PC]    = err_flags_q[ERR_PC]    | pc_bad;
        err_flags_d[ERR_UNDER] = err_flags_q[ERR_UNDER] | underflow;
        err_flags_d[ERR_OVER]  = err_flags_q[ERR_OVER]  | overflow;
        p0_miss_d = sat_inc(p0_miss_q, do_pop & (head.p0 != wb_taken));
        p1_miss_d = sat_inc(p1_miss_q, do_pop & (head.p1 != wb_taken));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags_q <= '0;
            p0_miss_q   <= '0;
            p1_miss_q   <= '0;
        end else begin
            err_flags_q <= err_flags_d;
            p0_miss_q   <= p0_miss_d;
            p1_miss_q   <= p1_miss_d;
        end
    end

    assign err_flags   = err_flags_q;
    assign p0_miss_cnt = p0_miss_q;
    assign p1_miss_cnt = p1_miss_q;

endmodule

// File: tb/tb_pred_outcome_tracker.sv
// Directed, table-driven bench for pred_outcome_tracker with hand-computed expectations.
module tb_pred_outcome_tracker;
    import pred_outcome_tracker_pkg::*;

    logic        clk, rst_n;
    logic        if_push, if_p0_taken, if_p1_taken, if_pred_select;
    logic [15:0] if_pc, wb_pcplus2;
    logic        wb_resolve, wb_taken, flush;
    logic        wbisbranch, p0_pred_correct, p1_pred_correct, mispredict, full, empty;
    logic [2:0]  count;
    logic [2:0]  err_flags;
    logic [15:0] p0_miss_cnt, p1_miss_cnt;

    int checks = 0;
    int errors = 0;

    pred_outcome_tracker #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_push(if_push), .if_pc(if_pc), .if_p0_taken(if_p0_taken),
        .if_p1_taken(if_p1_taken), .if_pred_select(if_pred_select),
        .wb_resolve(wb_resolve), .wb_pcplus2(wb_pcplus2), .wb_taken(wb_taken),
        .flush(flush), .wbisbranch(wbisbranch), .p0_pred_correct(p0_pred_correct),
        .p1_pred_correct(p1_pred_correct), .mispredict(mispredict),
        .full(full), .empty(empty), .count(count), .err_flags(err_flags),
        .p0_miss_cnt(p0_miss_cnt), .p1_miss_cnt(p1_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        push;
        logic [15:0] pc;
        logic        p0, p1, sel;
        logic        res;
        logic [15:0] pc2;
        logic        tk;
        logic        fl;
        logic        e_wbb, e_p0c, e_p1c, e_mis;
        int          e_cnt;
        int          e_err;
        int          e_p0m, e_p1m;
    } vec_t;

    function automatic vec_t mk(input logic push, input logic [15:0] pc, input logic p0,
                                input logic p1, input logic sel, input logic res,
                                input logic [15:0] pc2, input logic tk, input logic fl,
                                input logic wbb, input logic p0c, input logic p1c,
                                input logic mis, input int cnt, input int err,
                                input int p0m, input int p1m);
        vec_t v;
        v.push = push; v.pc = pc; v.p0 = p0; v.p1 = p1; v.sel = sel;
        v.res = res; v.pc2 = pc2; v.tk = tk; v.fl = fl;
        v.e_wbb = wbb; v.e_p0c = p0c; v.e_p1c = p1c; v.e_mis = mis;
        v.e_cnt = cnt; v.e_err = err; v.e_p0m = p0m; v.e_p1m = p1m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_push = 0; if_pc = '0; if_p0_taken = 0; if_p1_taken = 0; if_pred_select = 0;
        wb_resolve = 0; wb_pcplus2 = '0; wb_taken = 0; flush = 0;
    endtask

    // Drive on the falling edge, check WB outputs before the rising edge,
    // check registered state just after it.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        @(negedge clk);
        if_push = v.push; if_pc = v.pc; if_p0_taken = v.p0; if_p1_taken = v.p1;
        if_pred_select = v.sel; wb_resolve = v.res; wb_pcplus2 = v.pc2;
        wb_taken = v.tk; flush = v.fl;
        #1;
        chk($sformatf("%s[%0d].wbisbranch", tag, idx), 32'(wbisbranch), 32'(v.e_wbb));
        chk($sformatf("%s[%0d].p0_correct", tag, idx), 32'(p0_pred_correct), 32'(v.e_p0c));
        chk($sformatf("%s[%0d].p1_correct", tag, idx), 32'(p1_pred_correct), 32'(v.e_p1c));
        chk($sformatf("%s[%0d].mispredict", tag, idx), 32'(mispredict), 32'(v.e_mis));
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].count", tag, idx), 32'(count), 32'(v.e_cnt));
        chk($sformatf("%s[%0d].full", tag, idx), 32'(full), 32'(v.e_cnt == 4));
        chk($sformatf("%s[%0d].empty", tag, idx), 32'(empty), 32'(v.e_cnt == 0));
        chk($sformatf("%s[%0d].err_flags", tag, idx), 32'(err_flags), 32'(v.e_err));
        chk($sformatf("%s[%0d].p0_miss", tag, idx), 32'(p0_miss_cnt), 32'(v.e_p0m));
        chk($sformatf("%s[%0d].p1_miss", tag, idx), 32'(p1_miss_cnt), 32'(v.e_p1m));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"}, 32'(full), 32'd0);
        chk({tag, ".err_flags"}, 32'(err_flags), 32'd0);
        chk({tag, ".p0_miss"}, 32'(p0_miss_cnt), 32'd0);
        chk({tag, ".p1_miss"}, 32'(p1_miss_cnt), 32'd0);
        chk({tag, ".wbisbranch"}, 32'(wbisbranch), 32'd0);
        chk({tag, ".mispredict"}, 32'(mispredict), 32'd0);
    endtask

    vec_t ta[22];
    vec_t tb[6];
    vec_t hp[3];

    initial begin
        // single entry, tournament picks the wrong component; full/overflow/drain/underflow;
        // push+pop at full across pointer wrap
        ta[0]  = mk(1,16'h3000,1,0,1, 0,16'h0000,0,0, 0,0,0,0, 1,0, 0,0);
        ta[1]  = mk(0,16'h0000,0,0,0, 1,16'h3002,1,0, 1,1,0,1, 0,0, 0,1);
        ta[2]  = mk(1,16'h3100,0,0,0, 0,16'h0000,0,0, 0,0,0,0, 1,0, 0,1);
        ta[3]  = mk(1,16'h3102,1,1,0, 0,16'h0000,0,0, 0,0,0,0, 2,0, 0,1);
        ta[4]  = mk(1,16'h3104,0,1,1, 0,16'h0000,0,0, 0,0,0,0, 3,0, 0,1);
        ta[5]  = mk(1,16'h3106,1,0,0, 0,16'h0000,0,0, 0,0,0,0, 4,0, 0,1);
        ta[6]  = mk(1,16'h3108,1,1,1, 0,16'h0000,0,0, 0,0,0,0, 4,1, 0,1);
        ta[7]  = mk(0,16'h0000,0,0,0, 1,16'h3102,1,0, 1,0,0,1, 3,1, 1,2);
        ta[8]  = mk(0,16'h0000,0,0,0, 1,16'h3104,0,0, 1,0,0,1, 2,1, 2,3);
        ta[9]  = mk(0,16'h0000,0,0,0, 1,16'h3106,1,0, 1,0,1,0, 1,1, 3,3);
        ta[10] = mk(0,16'h0000,0,0,0, 1,16'h3108,1,0, 1,1,0,0, 0,1, 3,4);
        ta[11] = mk(0,16'h0000,0,0,0, 1,16'h310A,1,0, 0,0,0,0, 0,3, 3,4);
        ta[12] = mk(1,16'h3200,1,1,0, 0,16'h0000,0,0, 0,0,0,0, 1,3, 3,4);
        ta[13] = mk(1,16'h3202,0,0,1, 0,16'h0000,0,0, 0,0,0,0, 2,3, 3,4);
        ta[14] = mk(1,16'h3204,1,0,1, 0,16'h0000,0,0, 0,0,0,0, 3,3, 3,4);
        ta[15] = mk(1,16'h3206,0,1,0, 0,16'h0000,0,0, 0,0,0,0, 4,3, 3,4);
        ta[16] = mk(1,16'h3208,1,1,1, 1,16'h3202,1,0, 1,1,1,0, 4,3, 3,4);
        ta[17] = mk(1,16'h320A,0,0,0, 1,16'h3204,0,0, 1,1,1,0, 4,3, 3,4);
        ta[18] = mk(0,16'h0000,0,0,0, 1,16'h3206,0,0, 1,0,1,0, 3,3, 4,4);
        ta[19] = mk(0,16'h0000,0,0,0, 1,16'h3208,1,0, 1,0,1,1, 2,3, 5,4);
        ta[20] = mk(0,16'h0000,0,0,0, 1,16'h320A,1,0, 1,1,1,0, 1,3, 5,4);
        ta[21] = mk(0,16'h0000,0,0,0, 1,16'h320C,1,0, 1,0,0,1, 0,3, 6,5);

        // pre-reset fill for the mid-run reset sequence
        hp[0]  = mk(1,16'h3400,1,0,0, 0,16'h0000,0,0, 0,0,0,0, 1,3, 6,5);
        hp[1]  = mk(1,16'h3402,1,0,0, 0,16'h0000,0,0, 0,0,0,0, 2,3, 6,5);
        hp[2]  = mk(1,16'h3404,1,0,0, 0,16'h0000,0,0, 0,0,0,0, 3,3, 6,5);

        // flush with same-cycle resolve and push; then pc mismatch still pops
        tb[0]  = mk(1,16'h3300,1,0,0, 0,16'h0000,0,0, 0,0,0,0, 1,0, 0,0);
        tb[1]  = mk(1,16'h3302,0,1,1, 0,16'h0000,0,0, 0,0,0,0, 2,0, 0,0);
        tb[2]  = mk(1,16'h3304,1,1,0, 1,16'h3302,0,1, 1,0,1,1, 0,0, 1,0);
        tb[3]  = mk(0,16'h0000,0,0,0, 1,16'h3306,1,0, 0,0,0,0, 0,2, 1,0);
        tb[4]  = mk(1,16'h3000,1,1,0, 0,16'h0000,0,0, 0,0,0,0, 1,2, 1,0);
        tb[5]  = mk(0,16'h0000,0,0,0, 1,16'h3010,1,0, 1,1,1,0, 0,6, 1,0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) run_vec("A", i, ta[i]);
        for (int i = 0; i < 3; i++) run_vec("prefill", i, hp[i]);

        // asynchronous reset asserted between clock edges while count=3
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("post_reset");

        for (int i = 0; i < 6; i++) run_vec("B", i, tb[i]);

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
